// File: rtl/input_blk.sv
// input_blk -- UART receive front end for the vector accelerator host link.
//
// Deserialises 8N1 frames arriving on rx and queues each good byte in a
// small show-ahead FIFO. The oldest byte is presented on out, qualified by
// ready, and is popped by holding read high for one clk.
//
// Parameters:
//   CLK_FREQ   system clock frequency in Hz
//   BAUD       UART bit rate; CLK_FREQ/BAUD must be >= 4
//   FIFO_DEPTH FIFO entries, power of two, >= 2
//
// Ports:
//   clk      system clock, rising edge
//   rst_l    synchronous reset, active high
//   rx       asynchronous serial input, idles high
//   read     pop request, one pop per clk while high and ready
//   out[7:0] byte at FIFO head, 8'h00 when empty
//   ready    FIFO non-empty
//   overflow (only with INPUT_BLK_OVERFLOW_EN) sticky flag set by a byte
//            dropped on a full FIFO or by a framing error
//
// Optional feature macro: INPUT_BLK_OVERFLOW_EN
module input_blk #(
   parameter int CLK_FREQ   = 100_000_000,
   parameter int BAUD       = 115_200,
   parameter int FIFO_DEPTH = 2
) (
   input  logic       clk,
   input  logic       rst_l,
   input  logic       rx,
   input  logic       read,
   output logic [7:0] out,
   output logic       ready
`ifdef INPUT_BLK_OVERFLOW_EN
   ,
   output logic       overflow
`endif
);

   localparam int CLK_PER_BIT = CLK_FREQ / BAUD;
   localparam int HALF_BIT    = CLK_PER_BIT / 2;
   localparam int TW          = $clog2(CLK_PER_BIT);
   localparam int PW          = $clog2(FIFO_DEPTH);
   localparam int CW          = $clog2(FIFO_DEPTH + 1);

   localparam logic [TW-1:0] TICK_FULL = TW'(CLK_PER_BIT - 1);
   localparam logic [TW-1:0] TICK_HALF = TW'(HALF_BIT - 1);
   localparam logic [CW-1:0] CNT_FULL  = CW'(FIFO_DEPTH);

   typedef enum logic [1:0] {IDLE, START, DATA, STOP} rx_state_t;

   // ---------------------------------------------------------------
   // Two-flop synchroniser; resets to the idle (high) line level so a
   // reset never fakes a start bit.
   // ---------------------------------------------------------------
   logic [1:0] sync_q;
   logic       rxs;

   always_ff @(posedge clk) begin
      if (rst_l) sync_q <= 2'b11;
      else       sync_q <= {sync_q[0], rx};
   end

   assign rxs = sync_q[1];

   // ---------------------------------------------------------------
   // Receiver FSM. The tick counter measures half a bit in START so all
   // later samples land mid-bit; STOP returns to IDLE at mid-stop so the
   // next start edge is caught even when frames are back to back.
   // ---------------------------------------------------------------
   rx_state_t     state;
   logic [TW-1:0] tick;
   logic [2:0]    bit_cnt;
   logic [7:0]    shreg;
   logic          push;
   logic [7:0]    push_data;
`ifdef INPUT_BLK_OVERFLOW_EN
   logic          frame_err;
`endif

   always_ff @(posedge clk) begin
      if (rst_l) begin
         state     <= IDLE;
         tick      <= '0;
         bit_cnt   <= '0;
         shreg     <= '0;
         push      <= 1'b0;
         push_data <= '0;
`ifdef INPUT_BLK_OVERFLOW_EN
         frame_err <= 1'b0;
`endif
      end else begin
         push <= 1'b0;
`ifdef INPUT_BLK_OVERFLOW_EN
         frame_err <= 1'b0;
`endif
         case (state)
            IDLE: begin
               bit_cnt <= '0;
               if (!rxs) begin
                  state <= START;
                  tick  <= '0;
               end
            end
            START: begin
               if (tick == TICK_HALF) begin
                  tick  <= '0;
                  // a start bit gone high by mid-bit is line noise
                  state <= rxs ? IDLE : DATA;
               end else begin
                  tick <= tick + 1'b1;
               end
            end
            DATA: begin
               if (tick == TICK_FULL) begin
                  tick    <= '0;
                  shreg   <= {rxs, shreg[7:1]};  // LSB arrives first
                  bit_cnt <= bit_cnt + 1'b1;
                  if (bit_cnt == 3'd7) state <= STOP;
               end else begin
                  tick <= tick + 1'b1;
               end
            end
            STOP: begin
               if (tick == TICK_FULL) begin
                  tick  <= '0;
                  state <= IDLE;
                  if (rxs) begin
                     push      <= 1'b1;
                     push_data <= shreg;
                  end
`ifdef INPUT_BLK_OVERFLOW_EN
                  else begin
                     frame_err <= 1'b1;
                  end
`endif
               end else begin
                  tick <= tick + 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   // ---------------------------------------------------------------
   // Show-ahead FIFO. A pop on a full FIFO frees the slot in the same
   // cycle, so a coincident push is still accepted.
   // ---------------------------------------------------------------
   logic [7:0]    mem [FIFO_DEPTH];
   logic [PW-1:0] rd_ptr, wr_ptr;
   logic [CW-1:0] count;
   logic          pop, full, wr_en;

   assign pop   = read && (count != '0);
   assign full  = (count == CNT_FULL);
   assign wr_en = push && (!full || pop);

   always_ff @(posedge clk) begin
      if (rst_l) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (wr_en) wr_ptr <= wr_ptr + 1'b1;   // power-of-two depth wraps
         if (pop)   rd_ptr <= rd_ptr + 1'b1;
         case ({wr_en, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_l && wr_en) mem[wr_ptr] <= push_data;
   end

   assign ready = (count != '0);
   assign out   = ready ? mem[rd_ptr] : 8'h00;

`ifdef INPUT_BLK_OVERFLOW_EN
   logic drop;
   assign drop = push && full && !pop;

   always_ff @(posedge clk) begin
      if (rst_l)                  overflow <= 1'b0;
      else if (drop || frame_err) overflow <= 1'b1;
   end
`endif

endmodule

// File: tb/tb_input_blk.sv
// Self-checking bench for input_blk at CLK_PER_BIT = 10 (100 MHz / 10 MHz).
module tb_input_blk;

   logic       clk = 1'b0;
   logic       rst_l;
   logic       rx;
   logic       read;
   logic [7:0] out;
   logic       ready;
`ifdef INPUT_BLK_OVERFLOW_EN
   logic       overflow;
`endif

   int total  = 0;
   int passed = 0;

   always #5 clk = ~clk;

   input_blk #(
      .CLK_FREQ  (100_000_000),
      .BAUD      (10_000_000),
      .FIFO_DEPTH(2)
   ) dut (
      .clk     (clk),
      .rst_l   (rst_l),
      .rx      (rx),
      .read    (read),
      .out     (out),
      .ready   (ready)
`ifdef INPUT_BLK_OVERFLOW_EN
      ,
      .overflow(overflow)
`endif
   );

   typedef struct {
      logic [7:0] data;
      logic       stop;
      logic       exp_ready;
      logic [7:0] exp_out;
   } vec_t;

   task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %h, expected %h", name, act, exp);
   endtask

   task automatic cyc(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic send_bit(input logic b);
      rx = b;
      cyc(10);
   endtask

   // Full 8N1 frame; returns one bit time after the stop bit starts.
   task automatic send_byte(input logic [7:0] d, input logic stop);
      send_bit(1'b0);
      for (int i = 0; i < 8; i++) send_bit(d[i]);
      send_bit(stop);
      rx = 1'b1;
   endtask

   task automatic pop_one();
      read = 1'b1;
      cyc(1);
      read = 1'b0;
   endtask

   task automatic do_reset();
      rst_l = 1'b1;
      rx    = 1'b1;
      cyc(10);
      rst_l = 1'b0;
      cyc(2);
   endtask

   vec_t vecs [5];

   initial begin
      vecs[0] = '{8'h66, 1'b1, 1'b1, 8'h66};
      vecs[1] = '{8'hA5, 1'b0, 1'b0, 8'h00};  // framing error
      vecs[2] = '{8'h00, 1'b1, 1'b1, 8'h00};
      vecs[3] = '{8'hFF, 1'b1, 1'b1, 8'hFF};
      vecs[4] = '{8'h81, 1'b1, 1'b1, 8'h81};

      read  = 1'b0;
      rx    = 1'b1;
      rst_l = 1'b1;

      // reset state, during and after reset
      cyc(10);
      check("rst_ready", {7'd0, ready}, 8'h00);
      check("rst_out", out, 8'h00);
`ifdef INPUT_BLK_OVERFLOW_EN
      check("rst_overflow", {7'd0, overflow}, 8'h00);
`endif
      rst_l = 1'b0;
      cyc(5);
      check("idle_ready", {7'd0, ready}, 8'h00);
      check("idle_out", out, 8'h00);

      // single byte, held without read
      send_byte(8'h66, 1'b1);
      check("single_ready", {7'd0, ready}, 8'h01);
      check("single_out", out, 8'h66);
      cyc(20);
      check("single_hold", out, 8'h66);
      pop_one();
      check("single_pop_ready", {7'd0, ready}, 8'h00);
      check("single_pop_out", out, 8'h00);

      // table-driven frames
      for (int i = 0; i < 5; i++) begin
         do_reset();
         send_byte(vecs[i].data, vecs[i].stop);
         cyc(2);
         check($sformatf("vec%0d_ready", i), {7'd0, ready}, {7'd0, vecs[i].exp_ready});
         check($sformatf("vec%0d_out", i), out, vecs[i].exp_out);
         cyc(20);
         check($sformatf("vec%0d_ready_late", i), {7'd0, ready}, {7'd0, vecs[i].exp_ready});
`ifdef INPUT_BLK_OVERFLOW_EN
         check($sformatf("vec%0d_overflow", i), {7'd0, overflow}, {7'd0, ~vecs[i].stop});
`endif
         if (vecs[i].exp_ready) begin
            pop_one();
            check($sformatf("vec%0d_pop_ready", i), {7'd0, ready}, 8'h00);
         end
      end

      // two bytes back to back, then single pops
      do_reset();
      send_byte(8'h66, 1'b1);
      send_byte(8'h0F, 1'b1);
      cyc(2);
      check("two_out0", out, 8'h66);
      check("two_ready0", {7'd0, ready}, 8'h01);
      pop_one();
      check("two_out1", out, 8'h0F);
      check("two_ready1", {7'd0, ready}, 8'h01);
      pop_one();
      check("two_out2", out, 8'h00);
      check("two_ready2", {7'd0, ready}, 8'h00);

      // held read over-pops must not corrupt pointers
      send_byte(8'h11, 1'b1);
      send_byte(8'h22, 1'b1);
      cyc(2);
      read = 1'b1;
      cyc(5);
      read = 1'b0;
      check("held_ready", {7'd0, ready}, 8'h00);
      check("held_out", out, 8'h00);
      send_byte(8'h03, 1'b1);
      cyc(2);
      check("held_next_out", out, 8'h03);
      check("held_next_ready", {7'd0, ready}, 8'h01);
      pop_one();
      check("held_next_pop", {7'd0, ready}, 8'h00);

      // overflow: third byte dropped
      do_reset();
      send_byte(8'h66, 1'b1);
      send_byte(8'h0F, 1'b1);
      cyc(2);
`ifdef INPUT_BLK_OVERFLOW_EN
      check("ovf_before", {7'd0, overflow}, 8'h00);
`endif
      send_byte(8'h03, 1'b1);
      cyc(2);
`ifdef INPUT_BLK_OVERFLOW_EN
      check("ovf_after", {7'd0, overflow}, 8'h01);
`endif
      check("ovf_out0", out, 8'h66);
      pop_one();
      check("ovf_out1", out, 8'h0F);
      pop_one();
      check("ovf_empty", {7'd0, ready}, 8'h00);
      check("ovf_empty_out", out, 8'h00);

      // start glitch: 3 low cycles, then a valid frame
      do_reset();
      rx = 1'b0;
      cyc(3);
      rx = 1'b1;
      cyc(30);
      check("glitch_ready", {7'd0, ready}, 8'h00);
      send_byte(8'h3C, 1'b1);
      cyc(2);
      check("glitch_next_out", out, 8'h3C);
      check("glitch_next_ready", {7'd0, ready}, 8'h01);
      pop_one();

      // reset mid-frame discards the partial byte
      send_bit(1'b0);
      send_bit(1'b1);
      send_bit(1'b0);
      send_bit(1'b1);
      rx    = 1'b1;
      rst_l = 1'b1;
      cyc(2);
      rst_l = 1'b0;
      cyc(120);
      check("midrst_ready", {7'd0, ready}, 8'h00);
      send_byte(8'h5A, 1'b1);
      cyc(2);
      check("midrst_next_out", out, 8'h5A);
      check("midrst_next_ready", {7'd0, ready}, 8'h01);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule

// File: doc/input_blk.md
Name: input_blk

Overview:
UART receive front end for the vector accelerator host link. Deserialises 8N1 frames on rx at a fixed baud rate and pushes each received byte into a small show-ahead FIFO. Downstream logic sees the oldest byte on out, qualified by ready, and pops it with read.

Parameters:
CLK_FREQ, 100_000_000, system clock frequency in Hz.
BAUD, 115_200, UART bit rate in bits/s. Derived localparam CLK_PER_BIT = CLK_FREQ/BAUD (integer divide), must be >= 4.
FIFO_DEPTH, 2, FIFO entries; power of two, >= 2.

Ports:
clk  input  1  system clock; all logic on the rising edge.
rst_l  input  1  synchronous, active-high reset (asserted = 1, sampled on clk).
rx  input  1  asynchronous UART serial input; idles high.
read  input  1  pop request; level-sensitive, one pop per clk while high and ready=1.
out  output  8  byte at FIFO head (show-ahead).
ready  output  1  FIFO non-empty.

Behaviour:
- Reset (rst_l=1 at a clk edge) clears everything:
  - FIFO empty, pointers and count 0.
  - ready=0, out=8'h00.
  - Receiver FSM to IDLE; synchroniser flops to 1.
  - Applies mid-frame too: any partial byte is discarded.
- rx passes through a 2-flop synchroniser (always present). rxs is the synchronised value.
- Receiver FSM:
  - IDLE: bit counter 0. On rxs=0, go to START and clear the tick counter.
  - START: wait CLK_PER_BIT/2 cycles, then sample rxs at mid-bit. If 0, go to DATA. If 1 (glitch), return to IDLE.
  - DATA: every CLK_PER_BIT cycles sample rxs into a shift register, LSB first. After 8 samples go to STOP.
  - STOP: wait CLK_PER_BIT cycles, then sample rxs. If 1, assert a 1-cycle internal push with the assembled byte. If 0 (framing error), discard the byte. Return to IDLE in both cases. The FSM re-arms at mid-stop-bit, so back-to-back frames are accepted.
- Latency: push occurs about 2 + CLK_PER_BIT/2 + 9*CLK_PER_BIT cycles after the rx falling edge. ready rises the cycle after the push into an empty FIFO.
- FIFO:
  - Circular buffer of FIFO_DEPTH x 8 with rd_ptr, wr_ptr and a count register (0..FIFO_DEPTH).
  - out = mem[rd_ptr] when count>0, else 8'h00.
  - ready = (count != 0).
  - Pop when read=1 and count>0: rd_ptr advances and wraps modulo FIFO_DEPTH. read with count=0 is ignored.
  - Push when count<FIFO_DEPTH: write mem[wr_ptr], wr_ptr advances and wraps. A push while full drops the byte; stored data is unchanged.
  - Simultaneous push and pop: both take effect and count is unchanged. This holds when full (the pop frees the slot the same cycle) and when empty is not possible, since a pop requires count>0.
- No combinational path from rx to out or ready. out and ready depend only on registers.

Optional Feature:
Macro INPUT_BLK_OVERFLOW_EN.
- Defined: adds output port overflow (1 bit). It is set on any cycle a push is dropped because the FIFO is full, or a framing error occurs, and stays high (sticky) until reset. Reset value 0.
- Undefined: no overflow port or logic; drops and framing errors are silent.

Test Plan:
- All scenarios use CLK_FREQ=100 MHz, BAUD=10 MHz (CLK_PER_BIT=10).
- Reset: hold rst_l=1 for 10 cycles with rx=1 -> out=8'h00, ready=0. Release -> outputs unchanged while rx idle.
- Single byte: send 8'h66 -> ready rises about 97 cycles after the start edge, out=8'h66. Hold read=0 -> value persists.
- Two bytes, then pops: send 8'h66, then 8'h0F, no read -> out=8'h66, ready=1. read=1 for 1 cycle -> out=8'h0F, ready=1. read=1 for 1 more cycle -> ready=0, out=8'h00.
- Held read over-pop: two bytes queued, read=1 for 5 cycles -> exactly two pops, then ready=0. No pointer corruption: a later 8'h03 appears on out correctly.
- Overflow: send 8'h66, 8'h0F, 8'h03 with read=0 -> third byte dropped. Pops yield 8'h66 then 8'h0F. With INPUT_BLK_OVERFLOW_EN, overflow=1 after the third frame.
- Framing error and glitch:
  - Frame 8'hA5 with stop bit 0 -> no push, ready stays 0.
  - rx low for 3 cycles only -> FSM returns to IDLE, no push. A subsequent valid 8'h3C is received correctly.
  - Reset asserted mid-frame -> no push; the next frame is received correctly.
